// File: rtl/memory_reader_stream_burst.sv
// -----------------------------------------------------------------------------
// memory_reader_stream_burst
//
// Fetches one video frame from memory as line-aligned read bursts of at most
// MAX_BURST beats. It buffers the returned beats in an internal FIFO and
// streams them out as AXI-Stream pixels. tlast marks the end of each line and
// tuser marks the first pixel of the frame.
//
// A read burst is requested only when the FIFO has room for every beat that
// is already outstanding plus the new burst. The FIFO can therefore never
// overflow, and memory never needs back-pressure.
//
// Optional build macro:
//   MRS_LINE_STRIDE_EN - adds input line_stride (pixels per line in memory),
//                        latched at frame acceptance; values below
//                        frame_width are treated as frame_width.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   frame_height/width  frame geometry in lines / pixels (latched on accept)
//   frame_ready         start request, sampled only while idle
//   base_addr           byte address of pixel (0,0)
//   start_read          read request valid (held until arready)
//   read_addr/len       burst start byte address / beat count (1..MAX_BURST)
//   read_size/burst     constant 3'b010 / 2'b01 (INCR)
//   arready             request accepted
//   rdata, rvalid       read data beats (never back-pressured)
//   m_axis_*            pixel stream (tdata, tvalid, tready, tlast, tuser)
//   busy                frame in progress
//   frame_done          one-cycle pulse after the final pixel handshake
// -----------------------------------------------------------------------------
module memory_reader_stream_burst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           frame_height,
    input  logic [15:0]           frame_width,
    input  logic                  frame_ready,
    input  logic [ADDR_WIDTH-1:0] base_addr,
`ifdef MRS_LINE_STRIDE_EN
    input  logic [15:0]           line_stride,
`endif
    output logic                  start_read,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [31:0]           read_len,
    output logic [2:0]            read_size,
    output logic [1:0]            read_burst,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  rvalid,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BYTES = DATA_WIDTH / 8;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;

    // Latched geometry and burst pointer
    logic [15:0]             width_q, width_d;
    logic [15:0]             stride_q, stride_d;
    logic [31:0]             total_q, total_d;
    logic [15:0]             lines_left_q, lines_left_d;
    logic [15:0]             col_rem_q, col_rem_d;
    logic [ADDR_WIDTH-1:0]   line_base_q, line_base_d;
    logic [ADDR_WIDTH-1:0]   burst_addr_q, burst_addr_d;

    // FIFO and credit bookkeeping
    logic [DATA_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [CNT_W-1:0]        outstanding_q, outstanding_d;

    // Output-side counters and status
    logic [15:0]             col_q, col_d;
    logic [15:0]             row_q, row_d;
    logic [31:0]             pix_cnt_q, pix_cnt_d;
    logic                    busy_q, busy_d;
    logic                    frame_done_q, frame_done_d;

    logic                    accept_s;
    logic                    ar_hs_s;
    logic                    fifo_wr_s;
    logic                    tvalid_s;
    logic                    out_hs_s;
    logic [15:0]             len_s;
    logic [15:0]             next_len_s;
    logic [15:0]             after_rem_s;
    logic                    line_end_s;
    logic                    last_burst_s;
    logic [31:0]             credits_s;
    logic                    fits_next_s;
    logic [ADDR_WIDTH-1:0]   next_line_s;
    logic [15:0]             stride_in_s;
    logic                    drain_done_s;

`ifdef MRS_LINE_STRIDE_EN
    assign stride_in_s = (line_stride < frame_width) ? frame_width : line_stride;
`else
    assign stride_in_s = frame_width;
`endif

    assign accept_s  = (state_q == S_IDLE) && frame_ready &&
                       (frame_height != 16'd0) && (frame_width != 16'd0);
    assign ar_hs_s   = (state_q == S_ISSUE) && arready;
    // Beats with nothing outstanding are stale (e.g. from an abandoned frame)
    assign fifo_wr_s = rvalid && (outstanding_q != {CNT_W{1'b0}});
    assign tvalid_s  = (count_q != {CNT_W{1'b0}});
    assign out_hs_s  = tvalid_s && m_axis_tready;

    assign len_s        = (col_rem_q > 16'(MAX_BURST)) ? 16'(MAX_BURST) : col_rem_q;
    assign line_end_s   = (col_rem_q == len_s);
    assign last_burst_s = line_end_s && (lines_left_q == 16'd1);
    assign after_rem_s  = line_end_s ? width_q : (col_rem_q - len_s);
    assign next_len_s   = (after_rem_s > 16'(MAX_BURST)) ? 16'(MAX_BURST) : after_rem_s;
    assign credits_s    = 32'(FIFO_DEPTH) - 32'(count_q) - 32'(outstanding_q);
    // Credits left after reserving the current burst must cover the next one
    assign fits_next_s  = credits_s >= (32'(len_s) + 32'(next_len_s));
    assign next_line_s  = line_base_q + (ADDR_WIDTH'(stride_q) * ADDR_WIDTH'(BYTES));
    assign drain_done_s = (state_q == S_DRAIN) && (pix_cnt_d == total_q);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) state_d = S_ISSUE;
                else          state_d = S_IDLE;
            end
            S_ISSUE: begin
                if (!ar_hs_s)         state_d = S_ISSUE;
                else if (last_burst_s) state_d = S_DRAIN;
                else if (fits_next_s)  state_d = S_ISSUE;
                else                   state_d = S_WAIT;
            end
            S_WAIT: begin
                if (credits_s >= 32'(len_s)) state_d = S_ISSUE;
                else                         state_d = S_WAIT;
            end
            S_DRAIN: begin
                if (drain_done_s) state_d = S_IDLE;
                else              state_d = S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: read request channel
    always_comb begin
        start_read = 1'b0;
        read_addr  = {ADDR_WIDTH{1'b0}};
        read_len   = 32'd0;
        if (state_q == S_ISSUE) begin
            start_read = 1'b1;
            read_addr  = burst_addr_q;
            read_len   = {16'd0, len_s};
        end else begin
            start_read = 1'b0;
        end
    end

    assign read_size  = 3'b010;
    assign read_burst = 2'b01;

    // Geometry latch and burst pointer advance
    always_comb begin
        width_d      = width_q;
        stride_d     = stride_q;
        total_d      = total_q;
        lines_left_d = lines_left_q;
        col_rem_d    = col_rem_q;
        line_base_d  = line_base_q;
        burst_addr_d = burst_addr_q;
        if (accept_s) begin
            width_d      = frame_width;
            stride_d     = stride_in_s;
            total_d      = 32'(frame_height) * 32'(frame_width);
            lines_left_d = frame_height;
            col_rem_d    = frame_width;
            line_base_d  = base_addr;
            burst_addr_d = base_addr;
        end else if (ar_hs_s) begin
            if (line_end_s) begin
                lines_left_d = lines_left_q - 16'd1;
                col_rem_d    = width_q;
                line_base_d  = next_line_s;
                burst_addr_d = next_line_s;
            end else begin
                col_rem_d    = col_rem_q - len_s;
                burst_addr_d = burst_addr_q + (ADDR_WIDTH'(len_s) * ADDR_WIDTH'(BYTES));
            end
        end else begin
            col_rem_d = col_rem_q;
        end
    end

    // FIFO pointers, occupancy and outstanding-beat credits
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        if (fifo_wr_s) begin
            wr_ptr_d      = wr_ptr_q + PTR_W'(1);
            outstanding_d = outstanding_d - CNT_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (out_hs_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (ar_hs_s) begin
            outstanding_d = outstanding_d + CNT_W'(len_s);
        end else begin
            outstanding_d = outstanding_d;
        end
        // Simultaneous write and read leave the count unchanged
        count_d = count_q + (fifo_wr_s ? CNT_ONE : {CNT_W{1'b0}})
                          - (out_hs_s  ? CNT_ONE : {CNT_W{1'b0}});
    end

    // Output pixel position, frame progress and status flags
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        pix_cnt_d    = pix_cnt_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        if (accept_s) begin
            col_d     = 16'd0;
            row_d     = 16'd0;
            pix_cnt_d = 32'd0;
            busy_d    = 1'b1;
        end else if (out_hs_s) begin
            pix_cnt_d = pix_cnt_q + 32'd1;
            if (col_q == (width_q - 16'd1)) begin
                col_d = 16'd0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end else begin
            pix_cnt_d = pix_cnt_q;
        end
        if (drain_done_s) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // Datapath and status registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width_q       <= 16'd0;
            stride_q      <= 16'd0;
            total_q       <= 32'd0;
            lines_left_q  <= 16'd0;
            col_rem_q     <= 16'd0;
            line_base_q   <= {ADDR_WIDTH{1'b0}};
            burst_addr_q  <= {ADDR_WIDTH{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            rd_ptr_q      <= {PTR_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            outstanding_q <= {CNT_W{1'b0}};
            col_q         <= 16'd0;
            row_q         <= 16'd0;
            pix_cnt_q     <= 32'd0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            width_q       <= width_d;
            stride_q      <= stride_d;
            total_q       <= total_d;
            lines_left_q  <= lines_left_d;
            col_rem_q     <= col_rem_d;
            line_base_q   <= line_base_d;
            burst_addr_q  <= burst_addr_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pix_cnt_q     <= pix_cnt_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output
    always_ff @(posedge clk) begin
        if (fifo_wr_s) begin
            fifo_mem_q[wr_ptr_q] <= rdata;
        end
    end

    assign m_axis_tvalid = tvalid_s;
    assign m_axis_tdata  = tvalid_s ? fifo_mem_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
    assign m_axis_tlast  = tvalid_s && (col_q == (width_q - 16'd1));
    assign m_axis_tuser  = tvalid_s && (col_q == 16'd0) && (row_q == 16'd0);
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_memory_reader_stream_burst.sv
module tb_memory_reader_stream_burst;

    logic        clk;
    logic        rst_n;
    logic [15:0] frame_height;
    logic [15:0] frame_width;
    logic        frame_ready;
    logic [31:0] base_addr;
`ifdef MRS_LINE_STRIDE_EN
    logic [15:0] line_stride;
`endif
    logic        start_read;
    logic [31:0] read_addr;
    logic [31:0] read_len;
    logic [2:0]  read_size;
    logic [1:0]  read_burst;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int req_cnt = 0;
    int req_beats = 0;
    int pix_cnt = 0;

    logic [63:0] exp_req_q [$];
    logic [33:0] exp_pix_q [$];
    logic [31:0] beat_addr_q [$];

    memory_reader_stream_burst #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(16), .FIFO_DEPTH(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .frame_height(frame_height), .frame_width(frame_width),
        .frame_ready(frame_ready), .base_addr(base_addr),
`ifdef MRS_LINE_STRIDE_EN
        .line_stride(line_stride),
`endif
        .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
        .read_size(read_size), .read_burst(read_burst), .arready(arready),
        .rdata(rdata), .rvalid(rvalid),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory content: a fixed scramble of the byte address
    function automatic logic [31:0] pix_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h0F0F};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected requests and pixels for a frame
    task automatic push_frame(input logic [31:0] base, input int w, input int h, input int stride);
        for (int r = 0; r < h; r++) begin
            logic [31:0] lb;
            logic [31:0] a;
            int          rem;
            lb  = base + 32'(r * stride * 4);
            a   = lb;
            rem = w;
            while (rem > 0) begin
                int l;
                l = (rem > 16) ? 16 : rem;
                exp_req_q.push_back({a, 32'(l)});
                a   = a + 32'(l * 4);
                rem = rem - l;
            end
            for (int c = 0; c < w; c++) begin
                exp_pix_q.push_back({((r == 0) && (c == 0)) ? 1'b1 : 1'b0,
                                     (c == w - 1) ? 1'b1 : 1'b0,
                                     pix_of(lb + 32'(c * 4))});
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input int w, input int h, input int stride);
        push_frame(base, w, h, (stride < w) ? w : stride);
        @(posedge clk); #1;
        base_addr    = base;
        frame_width  = 16'(w);
        frame_height = 16'(h);
`ifdef MRS_LINE_STRIDE_EN
        line_stride  = 16'(stride);
`endif
        frame_ready  = 1'b1;
        @(posedge clk); #1;
        frame_ready  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while ((done_cnt == d0) && (k < budget)) begin
            @(posedge clk); #1;
            if (toggle) m_axis_tready = ~m_axis_tready;
            k++;
        end
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        chk({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
        chk({name, "_busy_after"}, 64'(busy), 64'd0);
        chk({name, "_pix_left"}, 64'(exp_pix_q.size()), 64'd0);
        chk({name, "_req_left"}, 64'(exp_req_q.size()), 64'd0);
    endtask

    // Read-request monitor: checks each accepted request and schedules its beats
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && start_read && arready) begin
                req_cnt++;
                req_beats += int'(read_len);
                if (exp_req_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got %0h/%0d expected none", read_addr, read_len);
                end else begin
                    e = exp_req_q.pop_front();
                    chk("req_addr_len", {read_addr, read_len}, e);
                end
                for (int i = 0; i < int'(read_len) && i < 64; i++) begin
                    beat_addr_q.push_back(read_addr + 32'(i * 4));
                end
            end
        end
    end

    // Memory responder: returns scheduled beats with a periodic gap
    initial begin
        int rc;
        rc = 0;
        forever begin
            @(posedge clk); #1;
            rc++;
            if ((beat_addr_q.size() > 0) && ((rc % 3) != 2)) begin
                rvalid = 1'b1;
                rdata  = pix_of(beat_addr_q.pop_front());
            end else begin
                rvalid = 1'b0;
                rdata  = 32'd0;
            end
        end
    end

    // Stream monitor: pops the scoreboard on every pixel handshake
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && frame_done) done_cnt++;
            if (rst_n && m_axis_tvalid && m_axis_tready) begin
                pix_cnt++;
                if (exp_pix_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL pix_unexpected: got %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_pix_q.pop_front();
                    chk("pix_user_last_data", {30'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 64'(e));
                end
            end
        end
    end

    task automatic chk_all_zero(input string name);
        chk({name, "_start_read"}, 64'(start_read), 64'd0);
        chk({name, "_read_addr"}, 64'(read_addr), 64'd0);
        chk({name, "_read_len"}, 64'(read_len), 64'd0);
        chk({name, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        chk({name, "_tdata"}, 64'(m_axis_tdata), 64'd0);
        chk({name, "_tlast_tuser"}, 64'({m_axis_tlast, m_axis_tuser}), 64'd0);
        chk({name, "_busy_done"}, 64'({busy, frame_done}), 64'd0);
    endtask

    initial begin
        int r0;
        int p0;
        int k;
        rst_n = 1'b0; frame_ready = 1'b0; frame_height = 16'd0; frame_width = 16'd0;
        base_addr = 32'd0; arready = 1'b1; m_axis_tready = 1'b1;
`ifdef MRS_LINE_STRIDE_EN
        line_stride = 16'd0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        chk("read_size", 64'(read_size), 64'h2);
        chk("read_burst", 64'(read_burst), 64'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two lines of four: 0x1000/4 then 0x1010/4
        start_frame(32'h1000, 4, 2, 4);
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd1);
        wait_done("t1", 300, 1'b0);

        // One line of twenty: 0x0/16 then 0x40/4
        start_frame(32'h0, 20, 1, 20);
        wait_done("t2", 300, 1'b0);

        // Toggling downstream ready
        start_frame(32'h5000, 20, 2, 20);
        wait_done("t3", 600, 1'b1);

        // Downstream stalled: requests must stop at FIFO capacity
        m_axis_tready = 1'b0;
        r0 = req_beats;
        start_frame(32'h2000, 64, 2, 64);
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("stall_beats_le_depth", 64'((req_beats - r0) <= 32), 64'd1);
        chk("stall_beats_some", 64'((req_beats - r0) >= 16), 64'd1);
        chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        wait_done("t4", 2000, 1'b0);

        // Address channel stalled: request held stable
        arready = 1'b0;
        r0 = req_cnt;
        start_frame(32'h3000, 4, 1, 4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_req", {31'd0, start_read, read_addr}, {31'd0, 1'b1, 32'h3000});
            chk("hold_len", 64'(read_len), 64'd4);
        end
        @(posedge clk); #1;
        arready = 1'b1;
        wait_done("t5", 300, 1'b0);
        chk("t5_one_request", 64'(req_cnt - r0), 64'd1);

        // Reset after five pixels, then restart
        p0 = pix_cnt;
        start_frame(32'h4000, 8, 2, 8);
        k = 0;
        while (((pix_cnt - p0) < 5) && (k < 300)) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t6_five_pixels", 64'(pix_cnt - p0), 64'd5);
        m_axis_tready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_all_zero("midreset");
        exp_pix_q.delete();
        exp_req_q.delete();
        beat_addr_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_axis_tready = 1'b1;
        start_frame(32'h4000, 4, 1, 4);
        wait_done("t6", 300, 1'b0);

        // Zero geometry is ignored
        @(posedge clk); #1;
        r0 = req_cnt;
        frame_height = 16'd0; frame_width = 16'd4; frame_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        frame_height = 16'd2; frame_width = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        frame_ready = 1'b0;
        @(negedge clk);
        chk("zero_geom_busy", 64'(busy), 64'd0);
        chk("zero_geom_start_read", 64'(start_read), 64'd0);
        chk("zero_geom_no_req", 64'(req_cnt - r0), 64'd0);

`ifdef MRS_LINE_STRIDE_EN
        // Stride 8 with width 4: second line at 0x20
        start_frame(32'h0, 4, 2, 8);
        wait_done("stride", 300, 1'b0);
        // Stride below width behaves as width
        start_frame(32'h100, 4, 2, 2);
        wait_done("stride_small", 300, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_reader_stream_burst.md
Name: memory_reader_stream_burst

Overview:
Parametrised successor to the frame memory reader. Fetches a frame from AXI memory as line-aligned bursts of at most MAX_BURST beats and buffers returned data in an internal FIFO. Streams pixels out on AXI Stream with per-line tlast and start-of-frame tuser. Sits between the AXI memory master and downstream video processing. Tolerates arbitrary m_axis_tready backpressure without losing data.

Parameters:
DATA_WIDTH, 32, bits per beat; one pixel per beat
ADDR_WIDTH, 32, memory address width
MAX_BURST, 16, maximum beats per read request; power of 2, ≤ FIFO_DEPTH
FIFO_DEPTH, 32, beat capacity of the internal buffer; power of 2

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
frame_height  in  16  lines per frame
frame_width  in  16  pixels per line
frame_ready  in  1  start request; sampled only in IDLE
base_addr  in  ADDR_WIDTH  byte address of pixel (0,0)
start_read  out  1  read request valid
read_addr  out  ADDR_WIDTH  burst start byte address
read_len  out  32  beats in this burst (1..MAX_BURST; not len-1)
read_size  out  3  constant 3'b010
read_burst  out  2  constant 2'b01 (INCR)
arready  in  1  request accepted when high with start_read
rdata  in  DATA_WIDTH  read data
rvalid  in  1  read data beat valid; no back-pressure toward memory
m_axis_tdata  out  DATA_WIDTH  pixel
m_axis_tvalid  out  1  FIFO not empty
m_axis_tready  in  1  downstream ready
m_axis_tlast  out  1  last pixel of line
m_axis_tuser  out  1  first pixel of frame
busy  out  1  high from frame acceptance until frame_done
frame_done  out  1  one-cycle pulse after the final pixel handshake

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all outputs 0; FIFO flushed; counters, credits and latched geometry cleared. Reset mid-frame abandons the frame. Beats with rvalid arriving after reset are discarded until the next accepted frame.
- IDLE: frame_ready=1 with height≠0 and width≠0 latches geometry and base_addr, sets busy, and moves to ISSUE. Zero geometry is ignored and the block stays in IDLE. frame_ready while busy is ignored.
- Burst split: bursts never cross a line. len = min(MAX_BURST, pixels remaining in the line). The address advances by len*(DATA_WIDTH/8). The next line starts at line_base + stride*(DATA_WIDTH/8); stride = frame_width unless the optional feature is enabled.
- Credit rule: credits = FIFO_DEPTH - fifo_count - outstanding_beats. A request is raised only if credits ≥ len. outstanding_beats increments by len on the arready handshake and decrements on each rvalid. The FIFO therefore never overflows.
- ISSUE: start_read=1 with stable read_addr/read_len until arready=1. That cycle: reserve credits and advance the burst pointer. Go to WAIT if credits are insufficient for the next burst, DRAIN if all bursts are issued, otherwise stay in ISSUE. Back-to-back requests are allowed.
- WAIT: start_read=0; return to ISSUE when credits ≥ next len.
- DRAIN: all requests issued; wait until the output pixel counter reaches height*width, then pulse frame_done, drop busy, and go to IDLE.
- FIFO: a write on rvalid and a read on (m_axis_tvalid & m_axis_tready) may occur in the same cycle, with no count change. Write-to-tvalid latency is 1 cycle. m_axis_tdata/tlast/tuser are held stable while tvalid=1 and tready=0.
- Output counters (col, row) advance only on handshake. tuser=1 iff col=0 and row=0. tlast=1 iff col=width-1. col wraps to 0 and row increments.
- Arithmetic: the pixel total is 32-bit (height*width). Address arithmetic wraps modulo 2^ADDR_WIDTH.

Optional Feature:
MRS_LINE_STRIDE_EN: adds input line_stride [15:0], in pixels, latched at frame acceptance. Line n starts at base_addr + n*line_stride*(DATA_WIDTH/8). line_stride < frame_width is treated as frame_width. Without the macro the port is absent and stride = frame_width.

Test Plan:
- width=4, height=2, base=0x1000, arready=1, tready=1 -> 2 requests (0x1000 len 4; 0x1010 len 4); 8 beats; tuser on beat 0; tlast on beats 3 and 7; one frame_done pulse.
- width=20, height=1 -> requests 0x0 len 16, then 0x40 len 4; tlast only on beat 19.
- width=64, height=2, FIFO_DEPTH=32, tready=0 for 200 cycles -> at most 32 beats requested while stalled; no data lost; output in order after release.
- arready held low 10 cycles -> start_read, read_addr and read_len stay stable; exactly one request recorded.
- Reset asserted mid-frame after 5 pixels -> next cycle all outputs 0; new frame_ready restarts at base_addr with tuser on the first pixel.
- height=0 with frame_ready=1 -> no start_read; busy stays 0. With MRS_LINE_STRIDE_EN, width=4, stride=8, base=0 -> second line request at 0x20.
